opcode_decoder: RTL and testbench

- Registered instruction decoder for the 16-bit basic computer control unit.
- Captures an instruction word and decodes the 3-bit opcode field into one-hot D7..D0.
- Also decodes the indirect bit and classifies the instruction as memory-reference, register-reference or I/O, exposing the 12-bit B field for register/I/O micro-op selection.
- Sits beside the instruction register; used by the sequencer from T2 onward.

---
 rtl/opcode_decoder.sv | 83 ++++++++
 tb/tb_opcode_decoder.sv | 118 +++++++++++
 2 files changed

// File: rtl/opcode_decoder.sv
// Registered opcode decoder for the 16-bit basic computer control unit.
// Optional OPCODE_DECODER_ILLEGAL_CHK_EN adds a registered illegal-B-field flag.
module opcode_decoder #(
  parameter int ADDR_BITS = 12,
  parameter int WIDTH     = ADDR_BITS + 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     instr,
  output logic [7:0]           d,
  output logic                 indirect,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 mem_ref,
  output logic                 reg_ref,
  output logic                 io_ref,
`ifdef OPCODE_DECODER_ILLEGAL_CHK_EN
  output logic                 illegal,
`endif
  output logic                 valid
);

  logic [2:0]           opc;
  logic                 ind_d, mem_d, reg_d, io_d;
  logic [7:0]           d_d, d_q;
  logic [ADDR_BITS-1:0] addr_d, addr_q;
  logic                 ind_q, mem_q, reg_q, io_q, valid_q;

  always_comb begin
    opc    = instr[ADDR_BITS+2:ADDR_BITS];
    ind_d  = instr[WIDTH-1];
    addr_d = instr[ADDR_BITS-1:0];
    d_d    = 8'h01 << opc;
    mem_d  = (opc != 3'b111);
    reg_d  = (opc == 3'b111) && !ind_d;
    io_d   = (opc == 3'b111) &&  ind_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      d_q     <= 8'h00;
      ind_q   <= 1'b0;
      addr_q  <= '0;
      mem_q   <= 1'b0;
      reg_q   <= 1'b0;
      io_q    <= 1'b0;
      valid_q <= 1'b0;
    end else if (load) begin
      d_q     <= d_d;
      ind_q   <= ind_d;
      addr_q  <= addr_d;
      mem_q   <= mem_d;
      reg_q   <= reg_d;
      io_q    <= io_d;
      valid_q <= 1'b1;
    end
  end

`ifdef OPCODE_DECODER_ILLEGAL_CHK_EN
  // Register/IO micro-ops must select exactly one B-field bit.
  logic onehot_b, illegal_d, illegal_q;
  always_comb begin
    onehot_b  = (addr_d != '0) && ((addr_d & (addr_d - 1'b1)) == '0);
    illegal_d = !mem_d && !onehot_b;
  end

  always_ff @(posedge clock) begin
    if (reset)     illegal_q <= 1'b0;
    else if (load) illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`endif

  assign d        = d_q;
  assign indirect = ind_q;
  assign addr     = addr_q;
  assign mem_ref  = mem_q;
  assign reg_ref  = reg_q;
  assign io_ref   = io_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_opcode_decoder.sv
// Table-driven self-checking bench for opcode_decoder.
// Define OPCODE_DECODER_ILLEGAL_CHK_EN to also check the illegal flag.
module tb_opcode_decoder;

  logic        clock, reset, load;
  logic [15:0] instr;
  logic [7:0]  d;
  logic        indirect, mem_ref, reg_ref, io_ref, valid;
  logic [11:0] addr;
`ifdef OPCODE_DECODER_ILLEGAL_CHK_EN
  logic        illegal;
`endif

  int errors = 0;
  int checks = 0;

  opcode_decoder #(.ADDR_BITS(12), .WIDTH(16)) dut (
    .clock(clock), .reset(reset), .load(load), .instr(instr),
    .d(d), .indirect(indirect), .addr(addr),
    .mem_ref(mem_ref), .reg_ref(reg_ref), .io_ref(io_ref),
`ifdef OPCODE_DECODER_ILLEGAL_CHK_EN
    .illegal(illegal),
`endif
    .valid(valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst, ld;
    logic [15:0] ins;
    logic [7:0]  ed;
    logic        eind;
    logic [11:0] eaddr;
    logic        emem, ereg, eio, evld, eill;
  } vec_t;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk("d", idx, 32'(d), 32'(v.ed));
    chk("indirect", idx, 32'(indirect), 32'(v.eind));
    chk("addr", idx, 32'(addr), 32'(v.eaddr));
    chk("mem_ref", idx, 32'(mem_ref), 32'(v.emem));
    chk("reg_ref", idx, 32'(reg_ref), 32'(v.ereg));
    chk("io_ref", idx, 32'(io_ref), 32'(v.eio));
    chk("valid", idx, 32'(valid), 32'(v.evld));
`ifdef OPCODE_DECODER_ILLEGAL_CHK_EN
    chk("illegal", idx, 32'(illegal), 32'(v.eill));
`endif
  endtask

  // Drive one cycle, then sample 1 time unit after the edge.
  task automatic step(input vec_t v, input int idx);
    reset = v.rst; load = v.ld; instr = v.ins;
    @(posedge clock); #1;
    chk_all(idx, v);
  endtask

  vec_t tbl [16];
  vec_t v;

  initial begin
    //          rst  ld  instr     d      ind  addr     mem  reg  io  vld  ill
    tbl[0]  = '{1'b1,1'b1,16'hFFFF,8'h00,1'b0,12'h000,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b1,16'hFFFF,8'h00,1'b0,12'h000,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b0,16'h7FFF,8'h00,1'b0,12'h000,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b1,16'h2123,8'h04,1'b0,12'h123,1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[4]  = '{1'b0,1'b1,16'hA456,8'h04,1'b1,12'h456,1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[5]  = '{1'b0,1'b0,16'h0000,8'h04,1'b1,12'h456,1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[6]  = '{1'b0,1'b0,16'h0000,8'h04,1'b1,12'h456,1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[7]  = '{1'b0,1'b0,16'h0000,8'h04,1'b1,12'h456,1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[8]  = '{1'b0,1'b1,16'h7800,8'h80,1'b0,12'h800,1'b0,1'b1,1'b0,1'b1,1'b0};
    tbl[9]  = '{1'b0,1'b1,16'hF080,8'h80,1'b1,12'h080,1'b0,1'b0,1'b1,1'b1,1'b0};
    tbl[10] = '{1'b0,1'b1,16'h7801,8'h80,1'b0,12'h801,1'b0,1'b1,1'b0,1'b1,1'b1};
    tbl[11] = '{1'b0,1'b1,16'h7000,8'h80,1'b0,12'h000,1'b0,1'b1,1'b0,1'b1,1'b1};
    tbl[12] = '{1'b0,1'b0,16'h7800,8'h80,1'b0,12'h000,1'b0,1'b1,1'b0,1'b1,1'b1};
    tbl[13] = '{1'b0,1'b1,16'h7800,8'h80,1'b0,12'h800,1'b0,1'b1,1'b0,1'b1,1'b0};
    tbl[14] = '{1'b0,1'b1,16'h1003,8'h02,1'b0,12'h003,1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[15] = '{1'b0,1'b1,16'hF0FF,8'h80,1'b1,12'h0FF,1'b0,1'b0,1'b1,1'b1,1'b1};

    reset = 1'b1; load = 1'b0; instr = 16'h0000;
    #1;
    for (int i = 0; i < 16; i++) step(tbl[i], i);

    // Back-to-back opcode sweep, no bubbles; addr bit 0 keeps 7xxx legal.
    for (int k = 0; k < 8; k++) begin
      v = '{1'b0, 1'b1, 16'((k << 12) | 1), 8'(1 << k), 1'b0, 12'h001,
            (k != 7), (k == 7), 1'b0, 1'b1, 1'b0};
      step(v, 100 + k);
    end

    // Restart sweep, then reset together with load mid-sequence.
    for (int k = 0; k < 4; k++) begin
      v = '{1'b0, 1'b1, 16'(k << 12), 8'(1 << k), 1'b0, 12'h000,
            1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      step(v, 200 + k);
    end
    v = '{1'b1, 1'b1, 16'hF4FF, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    step(v, 300);
    // Idle after reset keeps valid low.
    v = '{1'b0, 1'b0, 16'hF4FF, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    step(v, 301);
    v = '{1'b0, 1'b1, 16'h6ABC, 8'h40, 1'b0, 12'hABC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    step(v, 302);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
